// File: rtl/cla_seq_pkg.sv
// Shared types and helpers for the nibble-serial CLA adder.
package cla_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of 4-bit slices (RUN cycles) for a given operand width.
  function automatic int unsigned nibbles(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/cla_nibble_sequencer_if.sv
// Operand/result handshake bundle for cla_nibble_sequencer.
// With CLA_SEQ_SUB_EN defined, an extra 'sub' request bit travels with the operands.
interface cla_nibble_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
`ifdef CLA_SEQ_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             busy;

`ifdef CLA_SEQ_SUB_EN
  modport master (
    output in_valid, a, b, carry_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, busy
  );
  modport slave (
    input  in_valid, a, b, carry_in, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, busy
  );
`else
  modport master (
    output in_valid, a, b, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, busy
  );
  modport slave (
    input  in_valid, a, b, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out, busy
  );
`endif
endinterface

// File: rtl/cla_nibble_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
module cla_nibble_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:1] c;

  // Lookahead carries, each a flat sum of products of generate/propagate terms.
  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c[1] = g[0] | (p[0] & cin_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin_i);
    sum_o  = p ^ {c[3:1], cin_i};
    cout_o = c[4];
  end

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Nibble-serial wide adder: one 4-bit CLA slice reused for WIDTH/4 cycles, carry kept
// in a register between nibbles. Optional subtract mode via macro CLA_SEQ_SUB_EN.
module cla_nibble_sequencer
  import cla_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cla_nibble_sequencer_if.slave  bus
);
  localparam int unsigned NIBBLES = nibbles(WIDTH);
  localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("cla_nibble_sequencer: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [NIBBLE_W-1:0] slice_a, slice_b, slice_sum;
  logic                slice_cout;

  // Select the operand nibble addressed by the current index.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int unsigned n = 0; n < NIBBLES; n++) begin
      if (idx_q == IdxW'(n)) begin
        slice_a = a_q[NIBBLE_W*n +: NIBBLE_W];
        slice_b = b_q[NIBBLE_W*n +: NIBBLE_W];
      end
    end
  end

  cla_nibble_slice u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // Next-state logic: capture in IDLE, one nibble per cycle in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d = bus.a;
`ifdef CLA_SEQ_SUB_EN
          // Subtract as a + ~b + 1; carry_in is ignored in this mode.
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.carry_in;
`else
          b_d     = bus.b;
          carry_d = bus.carry_in;
`endif
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned n = 0; n < NIBBLES; n++) begin
          if (idx_q == IdxW'(n)) begin
            sum_d[NIBBLE_W*n +: NIBBLE_W] = slice_sum;
          end
        end
        carry_d = slice_cout;
        if (idx_q == LastIdx) begin
          cout_d  = slice_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.sum       = sum_q;
    bus.carry_out = cout_q;
  end

endmodule
